// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel round-robin multiplexer.
// Mode encodings and small index helpers used by the mux and its pick logic.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Wraps (base + offset) into the range 0..modulus-1.
    function automatic int wrap_add(input int base, input int offset, input int modulus);
        int sum_v;
        sum_v = base + offset;
        return sum_v % modulus;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: the first asserted request strictly after
// ptr, wrapping around and ending at ptr itself.
module rr_pick
    import mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic                found,
    output logic [SEL_W-1:0]    idx
);

    // Walk the offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        found = 1'b0;
        idx   = {SEL_W{1'b0}};
        for (int i = CHANNELS; i >= 1; i--) begin
            found = found | req[SEL_W'(wrap_add(int'(ptr), i, CHANNELS))];
            idx   = req[SEL_W'(wrap_add(int'(ptr), i, CHANNELS))]
                    ? SEL_W'(wrap_add(int'(ptr), i, CHANNELS)) : idx;
        end
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// N-channel WIDTH-bit multiplexer with a one-deep registered output, valid/ready
// handshake, and manual or round-robin channel selection.
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 2,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          selector,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      valid_out,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    data_r;
    logic [SEL_W-1:0]    sel_r;
    logic                valid_r;
    logic [SEL_W-1:0]    ptr_r;

    logic                load_en_s;
    logic                rr_found_s;
    logic [SEL_W-1:0]    rr_idx_s;
    logic                man_found_s;
    logic                cand_found_s;
    logic [SEL_W-1:0]    cand_idx_s;
    logic                grant_s;
    logic [WIDTH-1:0]    sel_data_s;
    logic [CHANNELS-1:0] ready_s;

    rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_rr_pick (
        .req   (in_valid),
        .ptr   (ptr_r),
        .found (rr_found_s),
        .idx   (rr_idx_s)
    );

    assign load_en_s   = !valid_r || out_ready;
    assign man_found_s = (int'(selector) < CHANNELS) && in_valid[selector];

    // Choose the candidate channel for the current mode.
    always_comb begin
        cand_found_s = 1'b0;
        cand_idx_s   = {SEL_W{1'b0}};
        if (mode == MODE_RR) begin
            cand_found_s = rr_found_s;
            cand_idx_s   = rr_idx_s;
        end else begin
            cand_found_s = man_found_s;
            cand_idx_s   = selector;
        end
    end

    // No grant is issued while reset is held, so nothing is consumed in that cycle.
    assign grant_s = cand_found_s && load_en_s && !reset;

    // One-hot grant decode and data select for the candidate channel.
    always_comb begin
        sel_data_s = {WIDTH{1'b0}};
        ready_s    = {CHANNELS{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            sel_data_s = (cand_idx_s == SEL_W'(k)) ? in_data[k*WIDTH +: WIDTH] : sel_data_s;
            ready_s[k] = grant_s && (cand_idx_s == SEL_W'(k));
        end
    end

    assign in_ready = ready_s;

    // Output register and round-robin pointer; ptr only follows round-robin grants.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r  <= {WIDTH{1'b0}};
            sel_r   <= {SEL_W{1'b0}};
            valid_r <= 1'b0;
            ptr_r   <= SEL_W'(CHANNELS - 1);
        end else if (load_en_s) begin
            if (cand_found_s) begin
                data_r  <= sel_data_s;
                sel_r   <= cand_idx_s;
                valid_r <= 1'b1;
                ptr_r   <= (mode == MODE_RR) ? cand_idx_s : ptr_r;
            end else begin
                data_r  <= data_r;
                sel_r   <= sel_r;
                valid_r <= 1'b0;
                ptr_r   <= ptr_r;
            end
        end else begin
            data_r  <= data_r;
            sel_r   <= sel_r;
            valid_r <= valid_r;
            ptr_r   <= ptr_r;
        end
    end

    assign data_out  = data_r;
    assign sel_out   = sel_r;
    assign valid_out = valid_r;

endmodule

// File: doc/mux_nx1_rr.md
# mux_nx1_rr

Parametrised N-channel, WIDTH-bit multiplexer with a registered output stage and a valid/ready handshake. It generalises the 1-bit and 2-bit 2x1 muxes to any channel count and width. It adds a round-robin auto-select mode alongside manual selection. It sits between several producer channels and a single consumer, and is the standard merge point for multi-source datapaths.

## Interface
- WIDTH, 2, bits per channel.
- CHANNELS, 4, number of input channels (≥2).
- SEL_W, $clog2(CHANNELS), local parameter (not overridable), selector width.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = manual (use selector), 1 = round-robin over valid channels.
- selector  in  SEL_W  channel index in manual mode; ignored in round-robin mode.
- in_data  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel valid.
- in_ready  out  CHANNELS  one-hot grant, combinational. Channel k's word is consumed this cycle when in_valid[k] and in_ready[k] are both high.
- data_out  out  WIDTH  registered selected word.
- sel_out  out  SEL_W  registered index of the channel that produced data_out.
- valid_out  out  1  data_out holds an unconsumed word.
- out_ready  in  1  consumer accepts data_out this cycle.

## Operation
- Output register is 1 deep. load_en = !valid_out || out_ready.
- Candidate channel:
  - Manual mode: candidate = selector, only if selector < CHANNELS and in_valid[selector]; otherwise no candidate.
  - Round-robin mode: candidate = first k with in_valid[k], searching ptr+1, ptr+2, … and wrapping modulo CHANNELS, ending at ptr itself.
- in_ready[candidate] = load_en. All other in_ready bits are 0. in_ready is all-zero when there is no candidate or load_en = 0.
- On a grant of channel c:
  - data_out <= in_data[c].
  - sel_out <= c.
  - valid_out <= 1.
  - In round-robin mode only, ptr <= c.
- load_en with no candidate: valid_out <= 0; data_out and sel_out hold their values.
- !load_en: all registers hold.
- ptr is not updated by manual-mode grants. On return to round-robin, the search resumes after the last round-robin grant.
- A mode or selector change takes effect on the same cycle's combinational grant. There is no pipeline flush. A word already held in the output register is unaffected.

## Timing
- Reset values: data_out = 0, sel_out = 0, valid_out = 0, ptr = CHANNELS-1 (so the first round-robin search starts at channel 0). in_ready = 0 while reset is high.
- Latency: a word granted in cycle t appears on data_out with valid_out = 1 in cycle t+1.
- Throughput: 1 word/cycle when out_ready is held high.
- Back-pressure: valid_out=1 with out_ready=0 holds data_out and sel_out stable and forces in_ready = 0.
- A simultaneous out_ready and new grant replace the word in the same edge. There is no bubble.
- Reset asserted mid-transfer: the held word is discarded. No in_ready is issued in the reset cycle.
- Round-robin fairness: with all channels continuously valid, each channel is granted exactly once every CHANNELS accepted words.

## Structure
- Shared package mux_pkg holds MODE_MANUAL = 1'b0 and MODE_RR = 1'b1.
- One sub-module, rr_pick #(CHANNELS):
  - Inputs: request vector and pointer.
  - Outputs: found flag and index of the first request after the pointer, with wrap.
  - Purely combinational.
- Top level contains the output register, ptr register, grant decode and data select.

## Test plan
- Reset, then manual mode, selector=2, in_valid=4'b0100, in_data ch2=2'b11, out_ready=1 -> in_ready=4'b0100. Next cycle data_out=2'b11, sel_out=2, valid_out=1.
- Manual mode, selector=1, in_valid=4'b1101 -> in_ready=0000. Next cycle valid_out=0.
- Round-robin mode, all channels valid, out_ready=1 for 8 cycles -> sel_out sequence 0,1,2,3,0,1,2,3 and valid_out continuously 1.
- Round-robin mode, in_valid=4'b1010, ptr=3 -> grant ch1, then ch3, then ch1.
- valid_out=1, out_ready=0 for 3 cycles with inputs changing -> data_out and sel_out stable, in_ready=0000. When out_ready rises, the next grant loads on the same edge.
- Reset asserted while valid_out=1 and out_ready=0 -> next cycle valid_out=0, data_out=0, sel_out=0. The first round-robin grant after reset goes to the lowest valid channel.
